// File: rtl/wb_timer_pkg.sv
// Shared constants and types for the wb_timer Wishbone machine timer.
// Register indices, CTRL/STATUS bit positions and a byte-lane merge helper.
package wb_timer_pkg;

  typedef enum logic [2:0] {
    IdxMtimeLo = 3'd0,
    IdxMtimeHi = 3'd1,
    IdxCmpLo   = 3'd2,
    IdxCmpHi   = 3'd3,
    IdxCtrl    = 3'd4,
    IdxStatus  = 3'd5,
    IdxRsvd6   = 3'd6,
    IdxRsvd7   = 3'd7
  } reg_idx_t;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlDivLsb   = 8;
  localparam int unsigned StatusIrqBit = 0;

  // Replace only the bytes whose select bit is set.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Tick divider for wb_timer: one tick every div+1 enabled clocks.
// Down-counter reloads from div on reaching zero and on reload.
module wb_timer_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  reload,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload || (en && (cnt_q == '0))) begin
      cnt_d = div;
    end else if (en) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign tick = en && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone B4 pipelined machine timer (64-bit MTIME/MTIMECMP, level irq).
// Define WB_TIMER_PRESCALER_EN to add the CTRL.DIV tick prescaler.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_stall,
  output logic        irq
);

  logic        req, bad, wr, rd_en;
  reg_idx_t    idx;
  logic        wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl;
  logic        tick;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        irq_q, irq_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata, ctrl_rdata;

  logic        unused_adr;
  assign unused_adr = ^{wb_adr[31:5], wb_adr[1:0]};

  assign req   = wb_cyc & wb_stb;
  assign idx   = reg_idx_t'(wb_adr[4:2]);
  assign bad   = req & ((idx > IdxStatus) | (wb_we & (idx == IdxStatus)));
  assign wr    = req & wb_we & ~bad;
  assign rd_en = req & ~wb_we & ~bad;

  assign wr_mlo  = wr & (idx == IdxMtimeLo);
  assign wr_mhi  = wr & (idx == IdxMtimeHi);
  assign wr_clo  = wr & (idx == IdxCmpLo);
  assign wr_chi  = wr & (idx == IdxCmpHi);
  assign wr_ctrl = wr & (idx == IdxCtrl);

`ifdef WB_TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [31:0]           ctrl_wdata;
  logic                  unused_ctrl_w;

  always_comb begin
    ctrl_rdata = '0;
    ctrl_rdata[CtrlEnBit] = en_q;
    ctrl_rdata[CtrlDivLsb +: PRESCALE_W] = div_q;
  end

  assign ctrl_wdata    = apply_sel(ctrl_rdata, wb_dat_i, wb_sel);
  assign unused_ctrl_w = ^ctrl_wdata;
  assign en_d  = wr_ctrl ? ctrl_wdata[CtrlEnBit] : en_q;
  assign div_d = wr_ctrl ? ctrl_wdata[CtrlDivLsb +: PRESCALE_W] : div_q;

  // Next-state DIV feeds the reload so a CTRL write takes effect at once.
  wb_timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_q),
    .div   (div_d),
    .reload(wr_ctrl),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  // Without the prescaler DIV reads 0; PRESCALE_W stays referenced.
  logic [PRESCALE_W-1:0] unused_div;
  assign unused_div = '0;

  always_comb begin
    ctrl_rdata = '0;
    ctrl_rdata[CtrlEnBit] = en_q;
  end

  assign en_d = (wr_ctrl && wb_sel[0]) ? wb_dat_i[CtrlEnBit] : en_q;
  assign tick = en_q;
`endif

  // A bus write to either MTIME half wins over the tick; no carry is applied.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mlo) begin
      mtime_d[31:0] = apply_sel(mtime_q[31:0], wb_dat_i, wb_sel);
    end else if (wr_mhi) begin
      mtime_d[63:32] = apply_sel(mtime_q[63:32], wb_dat_i, wb_sel);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr_clo) cmp_d[31:0]  = apply_sel(cmp_q[31:0], wb_dat_i, wb_sel);
    if (wr_chi) cmp_d[63:32] = apply_sel(cmp_q[63:32], wb_dat_i, wb_sel);
  end

  always_comb begin
    rdata = '0;
    case (idx)
      IdxMtimeLo: rdata = mtime_q[31:0];
      IdxMtimeHi: rdata = mtime_q[63:32];
      IdxCmpLo:   rdata = cmp_q[31:0];
      IdxCmpHi:   rdata = cmp_q[63:32];
      IdxCtrl:    rdata = ctrl_rdata;
      IdxStatus:  rdata[StatusIrqBit] = irq_q;
      default:    rdata = '0;
    endcase
  end

  assign irq_d = (mtime_q >= cmp_q);
  assign ack_d = req & ~bad;
  assign err_d = bad;
  assign dat_d = rd_en ? rdata : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q <= '0;
      cmp_q   <= CMP_RESET;
      en_q    <= 1'b0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack   = ack_q;
  assign wb_err   = err_q;
  assign wb_stall = 1'b0;
  assign irq      = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Scoreboard bench for wb_timer: stimulus pushes expected responses, a
// negedge monitor pops and compares them against each ack/err.
module tb_wb_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [3:0]  wb_sel = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_stall;
  logic        irq;

  wb_timer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_cyc  (wb_cyc),
    .wb_stb  (wb_stb),
    .wb_we   (wb_we),
    .wb_adr  (wb_adr),
    .wb_sel  (wb_sel),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack  (wb_ack),
    .wb_err  (wb_err),
    .wb_stall(wb_stall),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic        err;
    logic [31:0] lo;
    logic [31:0] hi;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(negedge clk) begin
    if (rst_n && (wb_ack || wb_err)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_response: got ack=%b err=%b dat=%h at cycle %0d, expected none",
                 wb_ack, wb_err, wb_dat_o, cyc_cnt);
      end else begin
        m_e = sb.pop_front();
        if ((wb_ack === m_e.err) || (wb_err !== m_e.err) || (cyc_cnt != m_e.cyc) ||
            $isunknown(wb_dat_o) || (wb_dat_o < m_e.lo) || (wb_dat_o > m_e.hi)) begin
          n_errors++;
          $display("FAIL bus_response: got ack=%b err=%b dat=%h cycle=%0d, expected err=%b dat=[%h..%h] cycle=%0d",
                   wb_ack, wb_err, wb_dat_o, cyc_cnt, m_e.err, m_e.lo, m_e.hi, m_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request for one cycle; called at posedge+1 and returns there.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input logic err,
                       input logic [31:0] lo, input logic [31:0] hi);
    exp_t e;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = adr; wb_sel = sel; wb_dat_i = dat;
    e.err = err; e.lo = lo; e.hi = hi; e.cyc = cyc_cnt + 1;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    issue(1'b1, adr, 4'hF, dat, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp);
    issue(1'b0, adr, 4'hF, 32'd0, 1'b0, exp, exp);
  endtask

  task automatic idle(input int n);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic drain();
    idle(0);
    for (int i = 0; i < 6 && sb.size() != 0; i++) @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      m_e = sb.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL missing_response: got no response, expected one at cycle %0d", m_e.cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", wb_ack, 1'b0);
    check("reset_err", wb_err, 1'b0);
    check("reset_dat", wb_dat_o, 32'd0);
    check("reset_irq", irq, 1'b0);
    check("stall", wb_stall, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset values.
    rd(32'h00, 32'd0);
    rd(32'h0C, 32'hFFFF_FFFF);
    rd(32'h08, 32'hFFFF_FFFF);
    rd(32'h10, 32'd0);
    drain();
    check("irq_after_reset", irq, 1'b0);

    // Free-running count.
    wr(32'h10, 32'd1);
    idle(10);
    issue(1'b0, 32'h00, 4'hF, 32'd0, 1'b0, 32'd10, 32'd12);
    drain();

    // Carry from LO into HI over three ticks.
    wr(32'h10, 32'd0);
    wr(32'h04, 32'd0);
    wr(32'h00, 32'hFFFF_FFFE);
    wr(32'h10, 32'd1);
    idle(2);
    wr(32'h10, 32'd0);
    rd(32'h04, 32'd1);
    rd(32'h00, 32'd1);
    drain();

    // Write to MTIME_LO beats the tick; next tick carries.
    wr(32'h10, 32'd1);
    wr(32'h00, 32'hFFFF_FFFF);
    wr(32'h10, 32'd0);
    rd(32'h04, 32'd2);
    rd(32'h00, 32'd0);
    drain();

    // Byte lanes and unimplemented CTRL bits.
    issue(1'b1, 32'h0C, 4'b0010, 32'h1234_5678, 1'b0, 32'd0, 32'd0);
    rd(32'h0C, 32'hFFFF_56FF);
    wr(32'h10, 32'hFFFF_FF00);
`ifdef WB_TIMER_PRESCALER_EN
    rd(32'h10, 32'h0000_FF00);
`else
    rd(32'h10, 32'h0000_0000);
`endif
    wr(32'h10, 32'd0);
    drain();

    // irq rise when MTIME reaches MTIMECMP, fall when MTIMECMP raised.
    wr(32'h04, 32'd0);
    wr(32'h00, 32'd0);
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'd5);
    idle(2);
    check("irq_before_run", irq, 1'b0);
    wr(32'h10, 32'd1);
    idle(0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("irq_rise_k%0d", k), irq, (k >= 6));
    end
    @(posedge clk); #1;
    rd(32'h14, 32'd1);
    wr(32'h08, 32'hFFFF_FFFF);
    idle(0);
    @(negedge clk);
    check("irq_hold", irq, 1'b1);
    @(negedge clk);
    check("irq_fall", irq, 1'b0);
    @(posedge clk); #1;
    wr(32'h10, 32'd0);
    drain();

    // Error responses without side effects, then back-to-back reads.
    issue(1'b0, 32'h18, 4'hF, 32'd0, 1'b1, 32'd0, 32'd0);
    issue(1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0);
    issue(1'b1, 32'h1C, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0);
    rd(32'h0000_0108, 32'hFFFF_FFFF);
    rd(32'h0C, 32'd0);
    rd(32'h10, 32'd0);
    rd(32'h14, 32'd0);
    drain();

`ifdef WB_TIMER_PRESCALER_EN
    // DIV=3: one increment every four clocks.
    wr(32'h04, 32'd0);
    wr(32'h00, 32'd0);
    wr(32'h10, 32'h0000_0301);
    for (int i = 1; i <= 9; i++) rd(32'h00, (i <= 4) ? 32'd0 : ((i <= 8) ? 32'd1 : 32'd2));
    drain();
`endif

    // Reset during an outstanding read drops the response.
    wr(32'h0C, 32'd0);
    wr(32'h10, 32'd1);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h00; wb_sel = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle(0);
    @(negedge clk);
    check("rst_mid_ack", wb_ack, 1'b0);
    check("rst_mid_err", wb_err, 1'b0);
    check("rst_mid_dat", wb_dat_o, 32'd0);
    check("rst_mid_irq", irq, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rd(32'h00, 32'd0);
    rd(32'h04, 32'd0);
    rd(32'h08, 32'hFFFF_FFFF);
    rd(32'h0C, 32'hFFFF_FFFF);
    rd(32'h10, 32'd0);
    rd(32'h14, 32'd0);
    drain();
    check("irq_after_rst", irq, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
